// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
//   Registered ALU with accumulator, start/busy/done handshake, status flags
//   and a multi-cycle shift-add multiply. It sits between the switch/button
//   front end and the 7-segment driver, which shows {result_hi, result}.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//   MUL_EN  1: op 3'b011 is a WIDTH-cycle unsigned multiply
//           0: op 3'b011 behaves as ADD
//
// Ports
//   CLK100MHZ   in   system clock, all state on the rising edge
//   CPU_RESETN  in   asynchronous active-low reset
//   start       in   operation request, sampled only while idle
//   op          in   {M, alu_op}: 000 ADD, 001 SUB, 010 INC, 011 MUL,
//                    100 AND, 101 OR, 110 XOR, 111 NOT A
//   a, b        in   operands (b replaced by the accumulator when use_acc=1)
//   use_acc     in   select accumulator as operand B
//   acc_clr     in   clear accumulator (idle only, wins over start)
//   busy        out  multiply in progress
//   done        out  one-cycle pulse: result/flags just updated
//   result      out  result low word (also written to the accumulator)
//   result_hi   out  multiply high word, 0 for all other ops
//   flag_z/c/v  out  zero, carry/borrow, signed overflow
// -----------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int WIDTH  = 4,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    input  logic             acc_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } alu_out_t;

    // Single-cycle datapath. Op 011 only reaches here when the multiplier is
    // disabled, in which case it is an ordinary ADD.
    function automatic alu_out_t alu_eval(input logic [2:0]       op_i,
                                          input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y);
        alu_out_t       o;
        logic [WIDTH:0] ext;
        o   = '0;
        ext = '0;
        case (op_i)
            3'b000, 3'b011: begin
                ext   = {1'b0, x} + {1'b0, y};
                o.res = ext[WIDTH-1:0];
                o.c   = ext[WIDTH];
                o.v   = (x[MSB] == y[MSB]) && (o.res[MSB] != x[MSB]);
            end
            3'b001: begin
                // The extra top bit of a (WIDTH+1)-bit difference is the borrow.
                ext   = {1'b0, x} - {1'b0, y};
                o.res = ext[WIDTH-1:0];
                o.c   = ext[WIDTH];
                o.v   = (x[MSB] != y[MSB]) && (o.res[MSB] != x[MSB]);
            end
            3'b010: begin
                ext   = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
                o.res = ext[WIDTH-1:0];
                o.c   = ext[WIDTH];
                o.v   = ~x[MSB] & o.res[MSB];
            end
            3'b100:  o.res = x & y;
            3'b101:  o.res = x | y;
            3'b110:  o.res = x ^ y;
            3'b111:  o.res = ~x;
            default: o = '0;
        endcase
        return o;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] mcand_r, mcand_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic [WIDTH-1:0] result_hi_r, result_hi_s;
    logic             z_r, z_s;
    logic             c_r, c_s;
    logic             v_r, v_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic [WIDTH-1:0] opnd_b_s;
    logic             is_mul_s;
    alu_out_t         alu_s;
    logic [WIDTH:0]   step_sum_s;

    // Next-state and next-output logic for the IDLE / MUL_RUN controller.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mcand_s     = mcand_r;
        hi_s        = hi_r;
        lo_s        = lo_r;
        acc_s       = acc_r;
        result_s    = result_r;
        result_hi_s = result_hi_r;
        z_s         = z_r;
        c_s         = c_r;
        v_s         = v_r;
        busy_s      = busy_r;
        done_s      = 1'b0;

        opnd_b_s = use_acc ? acc_r : b;
        is_mul_s = (MUL_EN == 1'b1) && (op == 3'b011);
        alu_s    = alu_eval(op, a, opnd_b_s);
        // Shift-add step: {hi,lo} holds partial product above the
        // not-yet-consumed multiplier bits; add, then shift right one place.
        step_sum_s = lo_r[0] ? ({1'b0, hi_r} + {1'b0, mcand_r}) : {1'b0, hi_r};

        case (state_r)
            ST_IDLE: begin
                if (acc_clr) begin
                    acc_s = '0;
                end else if (start) begin
                    if (is_mul_s) begin
                        mcand_s = a;
                        lo_s    = opnd_b_s;
                        hi_s    = '0;
                        cnt_s   = '0;
                        busy_s  = 1'b1;
                        state_s = ST_MUL_RUN;
                    end else begin
                        result_s    = alu_s.res;
                        result_hi_s = '0;
                        z_s         = (alu_s.res == {WIDTH{1'b0}});
                        c_s         = alu_s.c;
                        v_s         = alu_s.v;
                        acc_s       = alu_s.res;
                        done_s      = 1'b1;
                    end
                end else begin
                    acc_s = acc_r;
                end
            end
            ST_MUL_RUN: begin
                hi_s = step_sum_s[WIDTH:1];
                lo_s = {step_sum_s[0], lo_r[WIDTH-1:1]};
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    result_s    = lo_s;
                    result_hi_s = hi_s;
                    z_s         = ({hi_s, lo_s} == {(2 * WIDTH){1'b0}});
                    c_s         = (hi_s != {WIDTH{1'b0}});
                    v_s         = (hi_s != {WIDTH{1'b0}});
                    acc_s       = lo_s;
                    done_s      = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            mcand_r     <= '0;
            hi_r        <= '0;
            lo_r        <= '0;
            acc_r       <= '0;
            result_r    <= '0;
            result_hi_r <= '0;
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            v_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mcand_r     <= mcand_s;
            hi_r        <= hi_s;
            lo_r        <= lo_s;
            acc_r       <= acc_s;
            result_r    <= result_s;
            result_hi_r <= result_hi_s;
            z_r         <= z_s;
            c_r         <= c_s;
            v_r         <= v_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign flag_z    = z_r;
    assign flag_c    = c_r;
    assign flag_v    = v_r;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH=4, MUL_EN=1): an integer-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_alu_seq_unit;

    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         use_acc = 1'b0;
    logic         acc_clr = 1'b0;
    logic         busy, done, flag_z, flag_c, flag_v;
    logic [W-1:0] result, result_hi;

    int n_total = 0;
    int n_pass  = 0;

    alu_seq_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .use_acc   (use_acc),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    // Expected outcome of one operation, from plain integer arithmetic.
    function automatic exp_t eval(input int opv, input int x, input int y);
        exp_t e;
        int   s;
        int   ss;
        e = '0;
        case (opv)
            0, 2: begin
                if (opv == 2) y = 1;
                s  = x + y;
                ss = sgn(x) + sgn(y);
                e.res = s % MOD;
                e.c   = (s >= MOD);
                e.v   = (ss >= HALF) || (ss < -HALF);
            end
            1: begin
                s  = x - y;
                ss = sgn(x) - sgn(y);
                e.res = (s + MOD) % MOD;
                e.c   = (x < y);
                e.v   = (ss >= HALF) || (ss < -HALF);
            end
            3: begin
                s = x * y;
                e.res = s % MOD;
                e.hi  = s / MOD;
                e.c   = (s / MOD) != 0;
                e.v   = (s / MOD) != 0;
            end
            4: e.res = x & y;
            5: e.res = x | y;
            6: e.res = x ^ y;
            default: e.res = (~x) & (MOD - 1);
        endcase
        e.z = (e.res == 0) && (e.hi == 0);
        return e;
    endfunction

    // Reference model state
    int   m_pend = 0;
    int   m_acc = 0, m_ma = 0, m_mb = 0;
    exp_t m_out = '0;
    bit   m_busy = 1'b0, m_done = 1'b0;
    exp_t op_e, mul_e;

    always_comb op_e  = eval(int'(op), int'(a), use_acc ? m_acc : int'(b));
    always_comb mul_e = eval(3, m_ma, m_mb);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 0; m_acc <= 0; m_ma <= 0; m_mb <= 0;
            m_out <= '0; m_busy <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_pend > 0) begin
                m_pend <= m_pend - 1;
                if (m_pend == 1) begin
                    m_out  <= mul_e;
                    m_acc  <= int'(mul_e.res);
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (acc_clr) begin
                m_acc <= 0;
            end else if (start) begin
                if (op == 3'b011) begin
                    m_ma   <= int'(a);
                    m_mb   <= use_acc ? m_acc : int'(b);
                    m_pend <= W;
                    m_busy <= 1'b1;
                end else begin
                    m_out  <= op_e;
                    m_acc  <= int'(op_e.res);
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy",      busy,      m_busy);
            chk("done",      done,      m_done);
            chk("result",    result,    m_out.res);
            chk("result_hi", result_hi, m_out.hi);
            chk("flag_z",    flag_z,    m_out.z);
            chk("flag_c",    flag_c,    m_out.c);
            chk("flag_v",    flag_v,    m_out.v);
        end
    end

    task automatic issue(input logic [2:0] o, input int x, input int y, input bit ua);
        @(negedge clk);
        op = o; a = W'(x); b = W'(y); use_acc = ua; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("lit_reset_result", result, 32'd0);
        chk("lit_reset_busy",   busy,   32'd0);
        rst_n = 1'b1;

        // ADD 9+8
        issue(3'b000, 9, 8, 1'b0);
        chk("lit_add_done", done, 32'd1);
        chk("lit_add_res",  result, 32'd1);
        chk("lit_add_c",    flag_c, 32'd1);
        chk("lit_add_v",    flag_v, 32'd1);
        chk("lit_add_z",    flag_z, 32'd0);
        chk("lit_add_hi",   result_hi, 32'd0);

        // SUB 3-5
        issue(3'b001, 3, 5, 1'b0);
        chk("lit_sub_res", result, 32'he);
        chk("lit_sub_c",   flag_c, 32'd1);
        chk("lit_sub_v",   flag_v, 32'd0);

        // XOR A^A
        issue(3'b110, 10, 10, 1'b0);
        chk("lit_xor_res", result, 32'd0);
        chk("lit_xor_z",   flag_z, 32'd1);
        chk("lit_xor_c",   flag_c, 32'd0);

        // Remaining single-cycle ops, model-checked
        issue(3'b010, 7, 0, 1'b0);
        chk("lit_inc7_v", flag_v, 32'd1);
        issue(3'b010, 15, 0, 1'b0);
        issue(3'b100, 12, 10, 1'b0);
        chk("lit_and_res", result, 32'd8);
        issue(3'b101, 12, 3, 1'b0);
        issue(3'b111, 5, 0, 1'b0);
        chk("lit_not_res", result, 32'ha);
        issue(3'b001, 8, 1, 1'b0);

        // MUL 13*11 with a stray start mid-run
        issue(3'b011, 13, 11, 1'b0);
        chk("lit_mul_busy1", busy, 32'd1);
        op = 3'b000; a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("lit_mul_busy4", busy, 32'd1);
        chk("lit_mul_done4", done, 32'd0);
        @(negedge clk);
        chk("lit_mul_done", done, 32'd1);
        chk("lit_mul_busy", busy, 32'd0);
        chk("lit_mul_hi",   result_hi, 32'd8);
        chk("lit_mul_res",  result, 32'hf);
        chk("lit_mul_c",    flag_c, 32'd1);
        chk("lit_mul_v",    flag_v, 32'd1);

        // Accumulator clear, then accumulate +1 sixteen times with start held
        @(negedge clk); acc_clr = 1'b1;
        @(negedge clk); acc_clr = 1'b0;
        op = 3'b000; a = 4'd1; use_acc = 1'b1; start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("lit_acc_step", result, 32'(i % 16));
        end
        start = 1'b0;
        chk("lit_acc_wrap_z", flag_z, 32'd1);
        chk("lit_acc_wrap_c", flag_c, 32'd1);

        // acc_clr together with start: clear wins, no done
        issue(3'b000, 5, 0, 1'b0);
        @(negedge clk);
        op = 3'b000; a = 4'd1; use_acc = 1'b1; start = 1'b1; acc_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; acc_clr = 1'b0;
        chk("lit_clr_done", done, 32'd0);
        chk("lit_clr_hold", result, 32'd5);
        issue(3'b000, 0, 0, 1'b1);
        chk("lit_clr_acc0", result, 32'd0);

        // Reset in the middle of a multiply
        issue(3'b000, 3, 3, 1'b0);
        issue(3'b011, 15, 15, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_busy",   busy,      32'd0);
        chk("lit_rst_done",   done,      32'd0);
        chk("lit_rst_result", result,    32'd0);
        chk("lit_rst_hi",     result_hi, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b000, 2, 2, 1'b0);
        chk("lit_post_done", done, 32'd1);
        chk("lit_post_res",  result, 32'd4);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
